// File: rtl/riscv_defs.sv
// Shared RISC-V load/store definitions: funct3 width codes, LSU state encoding,
// byte-enable patterns and small decode helpers used by the load/store unit.
package riscv_defs;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_MEM  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_t;

    function automatic logic lsu_illegal(input logic write, input logic [2:0] funct3);
        if (write)
            return !(funct3 inside {F3_SB, F3_SH, F3_SW});
        return !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    endfunction

    // Access size lives in funct3[1:0] for both loads and stores.
    function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b01:   return offset[0];
            2'b10:   return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load lane
// extraction with sign or zero extension. Purely combinational.
module lsu_lane_align
    import riscv_defs::*;
(
    input  logic        write,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Halfwords pick their lane by offset[1] only, so a misaligned halfword
    // behaves like the aligned halfword containing it.
    assign rd_byte = rdata[{offset, 3'b000} +: 8];
    assign rd_half = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be         = BE_WORD;
        lane_wdata = wdata;
        if (write) begin
            case (funct3)
                F3_SB: begin
                    be         = BE_BYTE0 << offset;
                    lane_wdata = {4{wdata[7:0]}};
                end
                F3_SH: begin
                    be         = offset[1] ? BE_HALF_HI : BE_HALF_LO;
                    lane_wdata = {2{wdata[15:0]}};
                end
                default: begin
                    be         = BE_WORD;
                    lane_wdata = wdata;
                end
            endcase
        end
    end

    always_comb begin
        case (funct3)
            F3_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
            F3_LBU:  load_data = {24'h000000, rd_byte};
            F3_LH:   load_data = {{16{rd_half[15]}}, rd_half};
            F3_LHU:  load_data = {16'h0000, rd_half};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one access per handshake, word-aligned memory request, waits for ack or timeout.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses skip memory and report resp_misaligned.
module load_store_unit
    import riscv_defs::*;
#(
    parameter int TIMEOUT_CYCLES = 16
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        resp_misaligned,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam bit            TO_EN   = TIMEOUT_CYCLES > 0;
    localparam int            CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_t  state, state_nxt;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [CW-1:0] cnt;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        acc_illegal;
    logic        acc_mis;
    logic        timed_out;
    logic        in_mem;
    logic [3:0]  be_w;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    assign acc_illegal = lsu_illegal(req_write, req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;
    assign acc_mis = !acc_illegal && lsu_misaligned(req_funct3, req_addr[1:0]);
`else
    assign acc_mis = 1'b0;
`endif

    // cnt counts completed MEM cycles without ack; this edge is the last one allowed.
    assign timed_out = TO_EN && (cnt == TO_LAST) && !mem_ack;
    assign in_mem    = (state == LSU_MEM);

    lsu_lane_align u_align (
        .write      (write_q),
        .funct3     (funct3_q),
        .offset     (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (mem_rdata),
        .be         (be_w),
        .lane_wdata (lane_wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= LSU_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LSU_IDLE: begin
                if (req_valid)
                    state_nxt = (acc_illegal || acc_mis) ? LSU_RESP : LSU_MEM;
            end
            LSU_MEM: begin
                if (mem_ack || timed_out)
                    state_nxt = LSU_RESP;
            end
            LSU_RESP: begin
                if (resp_ready)
                    state_nxt = LSU_IDLE;
            end
            default: state_nxt = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        rdata_q  <= 32'h0;
                        err_q    <= acc_illegal;
                    end
                end
                LSU_MEM: begin
                    if (mem_ack)
                        rdata_q <= write_q ? 32'h0 : load_data;
                    else if (timed_out)
                        err_q <= 1'b1;
                end
                LSU_RESP: begin
                    if (resp_ready) begin
                        rdata_q <= 32'h0;
                        err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (in_mem && !mem_ack && TO_EN)
            cnt <= cnt + CW'(1);
        else
            cnt <= '0;
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            mis_q <= 1'b0;
        else if (state == LSU_IDLE && req_valid)
            mis_q <= acc_mis;
        else if (state == LSU_RESP && resp_ready)
            mis_q <= 1'b0;
    end
    assign resp_misaligned = mis_q;
`else
    assign resp_misaligned = 1'b0;
`endif

    assign req_ready  = (state == LSU_IDLE);
    assign resp_valid = (state == LSU_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign mem_req   = in_mem;
    assign mem_we    = in_mem && write_q;
    assign mem_addr  = in_mem ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_be    = in_mem ? be_w : BE_NONE;
    assign mem_wdata = (in_mem && write_q) ? lane_wdata : 32'h0;

endmodule
